// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment types, blanking constants and hex decode
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t      SEG_OFF = 7'h7F;
    localparam logic [7:0] DIG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; unknown inputs fall through to all-off.
    function automatic seg7_t hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            4'hF:    hex_to_seg = 7'h0E;
            default: hex_to_seg = SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex to active-low seven-segment decoder
module seg7_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed seven-segment scanner with blanking
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [2:0] Rom_addr_out,
    input  logic [3:0] Rom_data_in,
    output logic [6:0] seg_out,
    output logic [7:0] digit_sel,
    output logic       frame_done
);

    localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [7:0]    sel_q, sel_d;
    logic          frame_q, frame_d;
    logic [6:0]    dec_seg;
    logic          period_end;
    logic          show;

    seg7_decoder u_dec (
        .hex_i (Rom_data_in),
        .seg_o (dec_seg)
    );

    assign period_end = (div_cnt_q == DIV_LAST);
    // The ROM address is the live index so the digit read back matches idx_q this cycle.
    assign show       = enable && (div_cnt_q >= BLANK_END);

    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        frame_d   = 1'b0;
        sel_d     = DIG_OFF;
        seg_d     = SEG_OFF;
        if (enable) begin
            div_cnt_d = period_end ? '0 : div_cnt_q + 1'b1;
            if (period_end) begin
                idx_d   = idx_q + 3'd1;
                frame_d = (idx_q == 3'd7);
            end
        end
        if (show) begin
            sel_d = ~(8'b1 << idx_q);
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_OFF;
            sel_q     <= DIG_OFF;
            frame_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
            frame_q   <= frame_d;
        end
    end

    assign Rom_addr_out = idx_q;
    assign seg_out      = seg_q;
    assign digit_sel    = sel_q;
    assign frame_done   = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] Rom_addr_out;
    logic [3:0] Rom_data_in;
    logic [6:0] seg_out;
    logic [7:0] digit_sel;
    logic       frame_done;

    logic       use_rom;
    logic [3:0] drv_data;
    logic [3:0] rom_tab [8];
    logic [6:0] seg_by_idx [8];
    logic [6:0] dec_tab [16];
    logic [7:0] last_sel = 8'hFF;

    int n_cmp = 0;
    int n_err = 0;
    int dv    = 0;

    always #5 clk = ~clk;

    assign Rom_data_in = use_rom ? rom_tab[Rom_addr_out] : drv_data;

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .Rom_addr_out (Rom_addr_out),
        .Rom_data_in  (Rom_data_in),
        .seg_out      (seg_out),
        .digit_sel    (digit_sel),
        .frame_done   (frame_done)
    );

    always @(negedge clk) begin
        n_cmp++;
        if (!(digit_sel === 8'hFF || $countones(~digit_sel) == 1)) begin
            n_err++;
            $display("FAIL sel_onehot: digit_sel=%h required FF or a single low bit", digit_sel);
        end
        n_cmp++;
        if (digit_sel !== 8'hFF && last_sel !== 8'hFF && digit_sel !== last_sel) begin
            n_err++;
            $display("FAIL sel_gap: digit_sel went %h -> %h without an FF cycle", last_sel, digit_sel);
        end
        last_sel = digit_sel;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (seg_out !== 7'h7F || digit_sel !== 8'hFF || Rom_addr_out !== 3'd0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: seg=%h sel=%h addr=%0d fd=%b required 7F FF 0 0",
                     seg_out, digit_sel, Rom_addr_out, frame_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        enable = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            int pre_idx;
            logic [7:0] exp_sel;
            logic [6:0] exp_seg;
            logic [2:0] exp_addr;
            logic       exp_fd;
            pre_idx  = ((k - 1) / 4) % 8;
            exp_addr = 3'((k / 4) % 8);
            exp_fd   = (k % 32 == 0);
            if ((k - 1) % 4 == 0) begin
                exp_sel = 8'hFF;
                exp_seg = 7'h7F;
            end else begin
                exp_sel = ~(8'b1 << pre_idx);
                exp_seg = seg_by_idx[pre_idx];
            end
            step();
            n_cmp++;
            if (digit_sel !== exp_sel || seg_out !== exp_seg) begin
                n_err++;
                $display("FAIL scan_out k=%0d: sel=%h seg=%h required %h %h", k, digit_sel, seg_out, exp_sel, exp_seg);
            end
            n_cmp++;
            if (Rom_addr_out !== exp_addr || frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL scan_addr k=%0d: addr=%0d fd=%b required %0d %b", k, Rom_addr_out, frame_done, exp_addr, exp_fd);
            end
        end
    endtask

    task automatic test_frame_done();
        int pulses;
        int pos [3];
        pulses = 0;
        pos[0] = 0; pos[1] = 0; pos[2] = 0;
        for (int c = 1; c <= 96; c++) begin
            step();
            if (frame_done === 1'b1) begin
                if (pulses < 3) pos[pulses] = c;
                pulses++;
                n_cmp++;
                if (Rom_addr_out !== 3'd0) begin
                    n_err++;
                    $display("FAIL fd_at_wrap c=%0d: addr=%0d required 0", c, Rom_addr_out);
                end
            end
        end
        n_cmp++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL fd_count: pulses=%0d required 3", pulses);
        end
        n_cmp++;
        if (pos[0] != 32 || pos[1] != 64 || pos[2] != 96) begin
            n_err++;
            $display("FAIL fd_spacing: at %0d %0d %0d required 32 64 96", pos[0], pos[1], pos[2]);
        end
    endtask

    task automatic test_pause();
        repeat (14) step();
        n_cmp++;
        if (Rom_addr_out !== 3'd3 || digit_sel !== 8'hF7 || seg_out !== 7'h12) begin
            n_err++;
            $display("FAIL pause_pre: addr=%0d sel=%h seg=%h required 3 F7 12", Rom_addr_out, digit_sel, seg_out);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (digit_sel !== 8'hFF || seg_out !== 7'h7F || Rom_addr_out !== 3'd3 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL pause_hold i=%0d: sel=%h seg=%h addr=%0d fd=%b required FF 7F 3 0",
                         i, digit_sel, seg_out, Rom_addr_out, frame_done);
            end
        end
        enable = 1'b1;
        step();
        n_cmp++;
        if (digit_sel !== 8'hF7 || seg_out !== 7'h12 || Rom_addr_out !== 3'd3) begin
            n_err++;
            $display("FAIL resume_1: sel=%h seg=%h addr=%0d required F7 12 3", digit_sel, seg_out, Rom_addr_out);
        end
        step();
        n_cmp++;
        if (digit_sel !== 8'hF7 || seg_out !== 7'h12 || Rom_addr_out !== 3'd4) begin
            n_err++;
            $display("FAIL resume_2: sel=%h seg=%h addr=%0d required F7 12 4", digit_sel, seg_out, Rom_addr_out);
        end
        step();
        n_cmp++;
        if (digit_sel !== 8'hFF || seg_out !== 7'h7F || Rom_addr_out !== 3'd4) begin
            n_err++;
            $display("FAIL resume_3: sel=%h seg=%h addr=%0d required FF 7F 4", digit_sel, seg_out, Rom_addr_out);
        end
    endtask

    task automatic test_async_reset();
        repeat (5) step();
        n_cmp++;
        if (digit_sel !== 8'hDF || seg_out !== 7'h24 || Rom_addr_out !== 3'd5) begin
            n_err++;
            $display("FAIL arst_pre: sel=%h seg=%h addr=%0d required DF 24 5", digit_sel, seg_out, Rom_addr_out);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (seg_out !== 7'h7F || digit_sel !== 8'hFF || Rom_addr_out !== 3'd0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL arst_immediate: seg=%h sel=%h addr=%0d fd=%b required 7F FF 0 0",
                     seg_out, digit_sel, Rom_addr_out, frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_cmp++;
        if (digit_sel !== 8'hFF || seg_out !== 7'h7F || Rom_addr_out !== 3'd0) begin
            n_err++;
            $display("FAIL arst_restart_blank: sel=%h seg=%h addr=%0d required FF 7F 0", digit_sel, seg_out, Rom_addr_out);
        end
        step();
        n_cmp++;
        if (digit_sel !== 8'hFE || seg_out !== 7'h40 || Rom_addr_out !== 3'd0) begin
            n_err++;
            $display("FAIL arst_restart_digit0: sel=%h seg=%h addr=%0d required FE 40 0", digit_sel, seg_out, Rom_addr_out);
        end
        dv = 2;
    endtask

    task automatic test_decode();
        logic [3:0] probe;
        use_rom = 1'b0;
        for (int v = 0; v < 16; v++) begin
            drv_data = 4'(v);
            if (dv == 0) begin
                step();
                dv = 1;
                n_cmp++;
                if (seg_out !== 7'h7F) begin
                    n_err++;
                    $display("FAIL decode_blank v=%0d: seg=%h required 7F", v, seg_out);
                end
            end
            step();
            dv = (dv + 1) % 4;
            n_cmp++;
            if (seg_out !== dec_tab[v]) begin
                n_err++;
                $display("FAIL decode v=%0h: seg=%h required %h", v, seg_out, dec_tab[v]);
            end
        end
        probe = 4'bxxxx;
        if ($isunknown(probe)) begin
            drv_data = 4'bxxxx;
            if (dv == 0) begin
                step();
                dv = 1;
            end
            step();
            dv = (dv + 1) % 4;
            n_cmp++;
            if (seg_out !== 7'h7F) begin
                n_err++;
                $display("FAIL decode_x: seg=%h required 7F", seg_out);
            end
        end
        use_rom = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        use_rom  = 1'b1;
        drv_data = 4'h0;
        rom_tab[0] = 4'h0; rom_tab[1] = 4'h0; rom_tab[2] = 4'h9; rom_tab[3] = 4'h5;
        rom_tab[4] = 4'h7; rom_tab[5] = 4'h2; rom_tab[6] = 4'h0; rom_tab[7] = 4'h2;
        seg_by_idx[0] = 7'h40; seg_by_idx[1] = 7'h40; seg_by_idx[2] = 7'h10; seg_by_idx[3] = 7'h12;
        seg_by_idx[4] = 7'h78; seg_by_idx[5] = 7'h24; seg_by_idx[6] = 7'h40; seg_by_idx[7] = 7'h24;
        dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
        dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
        dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10; dec_tab[10] = 7'h08; dec_tab[11] = 7'h03;
        dec_tab[12] = 7'h46; dec_tab[13] = 7'h21; dec_tab[14] = 7'h06; dec_tab[15] = 7'h0E;

        test_reset();
        test_scan();
        test_frame_done();
        test_pause();
        test_async_reset();
        test_decode();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
